// File: rtl/joypad_dir_ctrl.sv
// Four-button direction controller: synchronize, debounce and edge-detect each button,
// arbitrate presses into a direction code, and expose it as a polled read-only register.
module joypad_dir_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] IO_ADDR         = 16'hFFFE,
  parameter bit          BLOCK_REVERSE   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [15:0] mem_addr,
  input  logic        mem_rd,
  output logic [15:0] rd_data,
  output logic        rd_hit,
  output logic [1:0]  dir,
  output logic        dir_valid,
  output logic        irq
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Button vectors are ordered {up, down, left, right}, matching rd_data[5:2].
  logic [3:0] raw;
  logic [3:0] sync1, sync2;
  logic [3:0] deb, deb_prev;
  logic [7:0] cnt [4];
  logic [3:0] rise;

  assign raw  = {up, down, left, right};
  assign rise = deb & ~deb_prev;

  // NOTE: sequential state is written with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      // NOTE: the counter array is small and its reset value is observable
      // (debounce timing after reset), so it is reset like ordinary flops.
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // Fixed-priority winner: up > down > left > right; losing presses are dropped.
  dir_t win;
  logic any_rise;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    win      = DIR_RIGHT;
    any_rise = |rise;
    if (rise[3])      win = DIR_UP;
    else if (rise[2]) win = DIR_DOWN;
    else if (rise[1]) win = DIR_LEFT;
    else if (rise[0]) win = DIR_RIGHT;
  end

  state_t     state, state_nxt;
  dir_t       dir_q, dir_nxt;
  logic       dir_valid_nxt;
  logic       overrun, overrun_nxt;
  logic       reversal;
  logic       accept;
  logic       io_rd;

  assign io_rd    = mem_rd && (mem_addr == IO_ADDR);
  assign reversal = BLOCK_REVERSE && dir_valid && (win == dir_t'(dir_q ^ 2'd2));
  assign accept   = any_rise && !reversal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dir_q     <= DIR_RIGHT;
      dir_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir_q     <= dir_nxt;
      dir_valid <= dir_valid_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    dir_nxt       = dir_q;
    dir_valid_nxt = dir_valid;
    overrun_nxt   = overrun;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt     = PENDING;
          dir_nxt       = win;
          dir_valid_nxt = 1'b1;
          overrun_nxt   = 1'b0;
        end
      end
      PENDING: begin
        if (accept) begin
          // A read in the same cycle consumes the old event; the new one stays pending.
          dir_nxt       = win;
          dir_valid_nxt = 1'b1;
          overrun_nxt   = !io_rd;
        end else if (io_rd) begin
          state_nxt   = IDLE;
          overrun_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic pending;
  assign pending = (state == PENDING);

  // Read register captures the pre-update view; non-matching reads leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end else begin
      rd_hit <= io_rd;
      if (io_rd) rd_data <= {pending, overrun, 8'h00, deb, dir_q};
    end
  end

  assign dir = dir_q;
  assign irq = pending;

endmodule

// File: tb/tb_joypad_dir_ctrl.sv
// Directed bench for joypad_dir_ctrl: a reversal-blocking and a reversal-permitting
// instance share stimulus; register reads are checked through an expected-value queue.
module tb_joypad_dir_ctrl;

  localparam logic [15:0] IO = 16'hFFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, up, down, left, right, mem_rd;
  logic [15:0] mem_addr;

  logic [15:0] a_rd_data, b_rd_data;
  logic        a_rd_hit, b_rd_hit, a_dir_valid, b_dir_valid, a_irq, b_irq;
  logic [1:0]  a_dir, b_dir;

  joypad_dir_ctrl #(.DEBOUNCE_CYCLES(16), .IO_ADDR(IO), .BLOCK_REVERSE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .rd_data(a_rd_data), .rd_hit(a_rd_hit),
    .dir(a_dir), .dir_valid(a_dir_valid), .irq(a_irq)
  );

  joypad_dir_ctrl #(.DEBOUNCE_CYCLES(16), .IO_ADDR(IO), .BLOCK_REVERSE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .rd_data(b_rd_data), .rd_hit(b_rd_hit),
    .dir(b_dir), .dir_valid(b_dir_valid), .irq(b_irq)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q [$];

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle read strobe; for IO reads the expected word goes through the queue.
  task automatic io_read(logic [15:0] addr, logic [15:0] exp, bit hit);
    if (hit) exp_q.push_back(exp);
    mem_addr = addr;
    mem_rd   = 1'b1;
    tick();
    mem_rd   = 1'b0;
    mem_addr = 16'h1234;
    check("rd_hit", {15'd0, a_rd_hit}, {15'd0, hit});
    if (hit) begin
      if (a_rd_hit && exp_q.size() > 0) begin
        check("rd_data", a_rd_data, exp_q.pop_front());
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL rd_data_missing: observed rd_hit=%0b expected a queued read", a_rd_hit);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end else begin
      check("rd_data_hold", a_rd_data, exp);
    end
    tick();
    check("rd_hit_drop", {15'd0, a_rd_hit}, 16'd0);
  endtask

  initial begin
    reset = 1'b1; up = 0; down = 0; left = 0; right = 0;
    mem_rd = 0; mem_addr = 16'h0000;
    #2 reset = 1'b0;

    // Reset with buttons toggling
    repeat (2) begin
      up = ~up; left = ~left;
      tick();
    end
    check("rst_dir",       {14'd0, a_dir}, 16'd1);
    check("rst_dir_valid", {15'd0, a_dir_valid}, 16'd0);
    check("rst_irq",       {15'd0, a_irq}, 16'd0);
    check("rst_rd_data",   a_rd_data, 16'h0000);
    check("rst_rd_hit",    {15'd0, a_rd_hit}, 16'd0);
    up = 0; left = 0;
    reset = 1'b1;
    tick(50);
    check("idle_irq",       {15'd0, a_irq}, 16'd0);
    check("idle_dir",       {14'd0, a_dir}, 16'd1);
    check("idle_dir_valid", {15'd0, a_dir_valid}, 16'd0);

    // Glitch shorter than the debounce window
    right = 1; tick(10); right = 0; tick(30);
    check("glitch_irq",       {15'd0, a_irq}, 16'd0);
    check("glitch_dir_valid", {15'd0, a_dir_valid}, 16'd0);

    // Held press: event on the 19th edge after the input rises
    right = 1; tick(18);
    check("lat_early_irq", {15'd0, a_irq}, 16'd0);
    tick(1);
    check("lat_irq",       {15'd0, a_irq}, 16'd1);
    check("lat_dir",       {14'd0, a_dir}, 16'd1);
    check("lat_dir_valid", {15'd0, a_dir_valid}, 16'd1);
    tick(6);
    io_read(IO, 16'h8005, 1'b1);
    check("after_read_irq", {15'd0, a_irq}, 16'd0);
    right = 0; tick(25);

    // Priority: up and left together
    up = 1; left = 1; tick(19);
    check("prio_dir", {14'd0, a_dir}, 16'd0);
    io_read(IO, 16'h8028, 1'b1);
    up = 0; left = 0; tick(25);

    // Back to right, then attempt a reversal to left
    right = 1; tick(19);
    check("right_dir", {14'd0, a_dir}, 16'd1);
    io_read(IO, 16'h8005, 1'b1);
    right = 0; tick(25);
    left = 1; tick(19);
    check("rev_a_dir", {14'd0, a_dir}, 16'd1);
    check("rev_a_irq", {15'd0, a_irq}, 16'd0);
    check("rev_b_dir", {14'd0, b_dir}, 16'd3);
    check("rev_b_irq", {15'd0, b_irq}, 16'd1);
    left = 0; tick(25);

    // Reset while an event is pending
    reset = 1'b0; tick(2);
    check("rst_pend_b_irq", {15'd0, b_irq}, 16'd0);
    check("rst_pend_b_dir", {14'd0, b_dir}, 16'd1);
    reset = 1'b1; tick(2);

    // Overrun: two accepted events without a read
    up = 1; tick(19);
    check("ovr_first_dir", {14'd0, a_dir}, 16'd0);
    up = 0; tick(25);
    right = 1; tick(19);
    check("ovr_dir", {14'd0, a_dir}, 16'd1);
    io_read(IO, 16'hC005, 1'b1);
    io_read(IO, 16'h0005, 1'b1);
    right = 0; tick(25);

    // Collision: read on the same edge as an accepted down event
    down = 1; tick(18);
    io_read(IO, 16'h0011, 1'b1);
    check("coll_irq", {15'd0, a_irq}, 16'd1);
    check("coll_dir", {14'd0, a_dir}, 16'd2);
    io_read(16'h0000, 16'h0011, 1'b0);
    io_read(IO, 16'h8012, 1'b1);
    down = 0; tick(25);

    // Button held through a reset that lands mid-debounce
    up = 1; tick(5);
    reset = 1'b0; tick(2);
    check("mid_rst_irq",     {15'd0, a_irq}, 16'd0);
    check("mid_rst_rd_data", a_rd_data, 16'h0000);
    check("mid_rst_dir",     {14'd0, a_dir}, 16'd1);
    reset = 1'b1; tick(18);
    check("held_early_irq", {15'd0, a_irq}, 16'd0);
    tick(1);
    check("held_irq",       {15'd0, a_irq}, 16'd1);
    check("held_dir",       {14'd0, a_dir}, 16'd0);
    check("held_dir_valid", {15'd0, a_dir_valid}, 16'd1);
    up = 0; tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
